// File: rtl/shift_add_multiplier.sv
// Sequential unsigned NxN shift-add multiplier on a single ripple-carry adder; done pulses N edges after start.
// No backpressure: start is honoured only in IDLE/DONE and ignored while busy; product holds until the next completion.

module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module rca #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         carry_in,
  output logic [N-1:0] sum,
  output logic         carry_out
);
  logic [N:0] c;

  assign c[0] = carry_in;

  for (genvar i = 0; i < N; i++) begin : g_bit
    full_adder u_fa (
      .x  (a[i]),
      .y  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  assign carry_out = c[N];
endmodule

module shift_add_multiplier #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   mcand_q, mcand_d;
  logic [N-1:0]   hi_q, hi_d;
  logic [N-1:0]   lo_q, lo_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] product_q, product_d;

  logic [N-1:0]   add_b;
  logic [N-1:0]   add_sum;
  logic           add_co;

  assign add_b = lo_q[0] ? mcand_q : '0;

  rca #(.N(N)) u_rca (
    .a         (hi_q),
    .b         (add_b),
    .carry_in  (1'b0),
    .sum       (add_sum),
    .carry_out (add_co)
  );

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mcand_d = a;
          hi_d    = '0;
          lo_d    = b;
          cnt_d   = '0;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        // carry_out becomes the new MSB so the full N+1-bit partial sum survives the shift
        hi_d  = {add_co, add_sum[N-1:1]};
        lo_d  = {add_sum[0], lo_q[N-1:1]};
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          product_d = {hi_d, lo_d};
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == BUSY);
  assign done    = (state_q == DONE);
  assign product = product_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed and random checks of shift_add_multiplier at N=8 and N=4 against a*b.
module tb_shift_add_multiplier;
  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [15:0] prod8;

  logic        start4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        busy4, done4;
  logic [7:0]  prod4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shift_add_multiplier #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(prod8)
  );

  shift_add_multiplier #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .product(prod4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One N=8 multiply; meddle re-pulses start and wiggles a/b mid-run.
  task automatic mul8(input logic [7:0] x, input logic [7:0] y, input bit meddle, input string tag);
    logic [15:0] old;
    int n, busy_cnt, extra;
    bit changed;
    old = prod8; n = 0; busy_cnt = 0; changed = 0; extra = 0;
    a8 = x; b8 = y; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check({tag, " busy_after_accept"}, busy8, 1);
    while (!done8 && n < 40) begin
      if (busy8) busy_cnt++;
      if (prod8 !== old) changed = 1;
      if (meddle && n == 3) begin start8 = 1'b1; a8 = 8'd9; b8 = 8'd9; end
      if (meddle && n == 4) begin start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); end
      tick();
      n++;
    end
    check({tag, " done_seen"}, done8, 1);
    check({tag, " edges_to_done"}, n, 8);
    check({tag, " busy_cycles"}, busy_cnt, 8);
    check({tag, " product_held"}, changed, 0);
    check({tag, " product"}, prod8, x * y);
    check({tag, " busy_in_done"}, busy8, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done8) extra++;
    end
    check({tag, " single_done"}, extra, 0);
  endtask

  task automatic mul4(input logic [3:0] x, input logic [3:0] y, input string tag);
    int n;
    n = 0;
    a4 = x; b4 = y; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    while (!done4 && n < 20) begin
      tick();
      n++;
    end
    check({tag, " done_seen"}, done4, 1);
    check({tag, " edges_to_done"}, n, 4);
    check({tag, " product"}, prod4, x * y);
    tick();
    check({tag, " done_drop"}, done4, 0);
  endtask

  initial begin
    int c, last, dones, n;
    logic [7:0] rx, ry;
    logic [3:0] qx, qy;

    rst = 1'b1;
    #1;
    check("rst busy8", busy8, 0);
    check("rst done8", done8, 0);
    check("rst prod8", prod8, 0);
    check("rst prod4", prod4, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    mul8(8'd13, 8'd11, 1'b0, "t1");
    mul8(8'd255, 8'd255, 1'b0, "t2");
    mul8(8'd0, 8'd200, 1'b0, "t3a");
    mul8(8'd200, 8'd0, 1'b0, "t3b");
    mul8(8'd6, 8'd7, 1'b1, "t4");

    // Asynchronous reset mid-operation
    a8 = 8'd100; b8 = 8'd100; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("t5 busy_before_rst", busy8, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t5 rst busy", busy8, 0);
    check("t5 rst done", done8, 0);
    check("t5 rst prod", prod8, 0);
    tick();
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8 || busy8) dones++;
    end
    check("t5 no_done_after_rst", dones, 0);
    mul8(8'd3, 8'd5, 1'b0, "t5b");

    // start held high: done every 9 cycles
    a8 = 8'd15; b8 = 8'd17; start8 = 1'b1;
    tick();
    last = -1; dones = 0;
    for (c = 1; c <= 40; c++) begin
      tick();
      if (done8) begin
        check("t6 held product", prod8, 255);
        if (last < 0) check("t6 first_done", c, 8);
        else          check("t6 period", c - last, 9);
        last = c;
        dones++;
      end
    end
    check("t6 done_count", dones, 4);
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 20) begin tick(); n++; end
    check("t6 drain", done8, 1);
    tick();

    mul4(4'd15, 4'd15, "t6 n4");

    for (int k = 0; k < 12; k++) begin
      rx = 8'($urandom); ry = 8'($urandom);
      mul8(rx, ry, 1'b0, "rand8");
    end
    for (int k = 0; k < 8; k++) begin
      qx = 4'($urandom); qy = 4'($urandom);
      mul4(qx, qy, "rand4");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
